// File: rtl/fifo_v4.sv
// fifo_v4 - parametrised FIFO with occupancy, runtime almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a high-water mark.
//
// Parameters:
//   FALL_THROUGH : 1 -> a push into an empty FIFO shows on data_o in the same cycle
//   DATA_WIDTH   : payload width
//   DEPTH        : number of entries (>= 2, any value, not only powers of two)
//   CNT_W        : derived occupancy width, leave at default
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   flush_i                : synchronous clear of pointers, count, flags, watermark
//   testmode_i             : forces the storage clock enable on (scan)
//   data_i, push_i         : push side
//   data_o, pop_i          : pop side, data_o is the current head
//   full_o, empty_o        : occupancy flags
//   usage_o                : registered occupancy 0..DEPTH
//   alm_full_th_i/_o       : usage_o >= threshold
//   alm_empty_th_i/_o      : usage_o <= threshold
//   err_clr_i              : clears sticky errors and reloads watermark
//   overflow_o/underflow_o : sticky request-while-full / request-while-empty
//   max_usage_o            : high-water mark since last clear
module fifo_v4 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      usage_o,
  input  logic [CNT_W-1:0]      alm_full_th_i,
  input  logic [CNT_W-1:0]      alm_empty_th_i,
  output logic                  alm_full_o,
  output logic                  alm_empty_o,
  input  logic                  err_clr_i,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [CNT_W-1:0]      max_usage_o
);

  localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2) begin : g_depth_err
    $error("fifo_v4: DEPTH must be >= 2");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      max_q, max_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic ft_bypass, pass_thru;
  logic push_acc, pop_acc, wr_en, rd_en, mem_en;

  // Fall-through: an empty FIFO with a push present presents data_i directly;
  // if the word is also popped it never touches storage.
  assign ft_bypass = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign pass_thru = ft_bypass && pop_i;

  assign full_o  = (cnt_q == DEPTH_CNT);
  assign empty_o = (cnt_q == '0) && !ft_bypass;
  assign data_o  = ft_bypass ? data_i : mem_q[rd_ptr_q];

  assign usage_o     = cnt_q;
  assign alm_full_o  = (cnt_q >= alm_full_th_i);
  assign alm_empty_o = (cnt_q <= alm_empty_th_i);
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign max_usage_o = max_q;

  assign push_acc = push_i && !full_o;
  assign pop_acc  = pop_i && !empty_o;
  assign wr_en    = push_acc && !pass_thru && !flush_i;
  assign rd_en    = pop_acc && !pass_thru && !flush_i;

  // Storage clock enable: stands in for an ICG whose enable is forced in test mode.
  // mem_d defaults to mem_q, so forced clocking never corrupts contents.
  assign mem_en = wr_en || testmode_i;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Error flags: a new offending request wins over a clear in the same cycle.
  always_comb begin
    ovf_d = (push_i && full_o) || (ovf_q && !(err_clr_i || flush_i));
    unf_d = (pop_i && empty_o) || (unf_q && !(err_clr_i || flush_i));
    max_d = max_q;
    if (flush_i || err_clr_i) begin
      max_d = cnt_d;
    end else if (cnt_d > max_q) begin
      max_d = cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      max_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_en) begin
      mem_q <= mem_d;
    end
  end

`ifndef SYNTHESIS
  push_full_warn : assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
    else $warning("fifo_v4: push while full, request dropped");
  pop_empty_warn : assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
    else $warning("fifo_v4: pop while empty, request dropped");
`endif

endmodule

// File: tb/tb_fifo_v4.sv
module tb_fifo_v4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0, testmode_i = 1'b0, err_clr_i = 1'b0;
  logic          push_i = 1'b0, pop_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic          full_o, empty_o, alm_full_o, alm_empty_o, overflow_o, underflow_o;
  logic [CW-1:0] usage_o, max_usage_o;
  logic [CW-1:0] alm_full_th_i = '0, alm_empty_th_i = '0;

  logic          ft_push_i = 1'b0, ft_pop_i = 1'b0;
  logic [DW-1:0] ft_data_i = '0;
  logic [DW-1:0] ft_data_o;
  logic          ft_full_o, ft_empty_o, ft_alm_full_o, ft_alm_empty_o, ft_ovf_o, ft_unf_o;
  logic [CW-1:0] ft_usage_o, ft_max_o;

  fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .testmode_i(testmode_i),
    .data_i(data_i), .push_i(push_i), .data_o(data_o), .pop_i(pop_i),
    .full_o(full_o), .empty_o(empty_o), .usage_o(usage_o),
    .alm_full_th_i(alm_full_th_i), .alm_empty_th_i(alm_empty_th_i),
    .alm_full_o(alm_full_o), .alm_empty_o(alm_empty_o), .err_clr_i(err_clr_i),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .max_usage_o(max_usage_o)
  );

  fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut_ft (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .testmode_i(testmode_i),
    .data_i(ft_data_i), .push_i(ft_push_i), .data_o(ft_data_o), .pop_i(ft_pop_i),
    .full_o(ft_full_o), .empty_o(ft_empty_o), .usage_o(ft_usage_o),
    .alm_full_th_i(alm_full_th_i), .alm_empty_th_i(alm_empty_th_i),
    .alm_full_o(ft_alm_full_o), .alm_empty_o(ft_alm_empty_o), .err_clr_i(err_clr_i),
    .overflow_o(ft_ovf_o), .underflow_o(ft_unf_o), .max_usage_o(ft_max_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: queue of stored words plus sticky flags and watermark.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf;
  int unsigned   m_max;
  int unsigned   n_chk = 0, n_pass = 0;

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_max = 0;
  endtask

  // Drive one clock cycle on the main FIFO and advance the model; returns at posedge+1.
  task automatic cycle(input bit push, input bit pop, input logic [DW-1:0] din,
                       input bit flush, input bit eclr);
    bit full, empty;
    push_i = push; pop_i = pop; data_i = din; flush_i = flush; err_clr_i = eclr;
    @(posedge clk_i);
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    m_ovf = (push && full) || (m_ovf && !(eclr || flush));
    m_unf = (pop && empty) || (m_unf && !(eclr || flush));
    if (flush) begin
      mq.delete();
    end else begin
      if (pop && !empty) void'(mq.pop_front());
      if (push && !full) mq.push_back(din);
    end
    if (flush || eclr) m_max = mq.size();
    else if (mq.size() > m_max) m_max = mq.size();
    #1;
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    alm_full_th_i = '0; alm_empty_th_i = '0;
    #1;
    n_chk++; if (usage_o !== '0) $display("FAIL rst_usage: got %0d exp 0", usage_o); else n_pass++;
    n_chk++; if (empty_o !== 1'b1 || full_o !== 1'b0)
      $display("FAIL rst_flags: empty %b full %b exp 1 0", empty_o, full_o); else n_pass++;
    n_chk++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0 || max_usage_o !== '0)
      $display("FAIL rst_err: ovf %b unf %b max %0d exp 0 0 0", overflow_o, underflow_o, max_usage_o);
    else n_pass++;
    n_chk++; if (alm_full_o !== 1'b1 || alm_empty_o !== 1'b1)
      $display("FAIL rst_alm_th0: af %b ae %b exp 1 1", alm_full_o, alm_empty_o); else n_pass++;
    alm_full_th_i = 3'd3;
    #1;
    n_chk++; if (alm_full_o !== 1'b0) $display("FAIL rst_alm_th3: af %b exp 0", alm_full_o); else n_pass++;
    repeat (2) @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    model_reset();
  endtask

  task automatic test_fill_drain();
    alm_full_th_i = 3'd4; alm_empty_th_i = 3'd1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, DW'(8'hA1 + i), 1'b0, 1'b0);
      n_chk++; if (usage_o !== CW'(i + 1)) $display("FAIL fill_usage: got %0d exp %0d", usage_o, i + 1); else n_pass++;
      n_chk++; if (alm_empty_o !== (i + 1 <= 1) || alm_full_o !== (i + 1 >= 4))
        $display("FAIL fill_alm: usage %0d ae %b af %b", i + 1, alm_empty_o, alm_full_o); else n_pass++;
      n_chk++; if (full_o !== (i + 1 == DEPTH)) $display("FAIL fill_full: got %b at usage %0d", full_o, i + 1); else n_pass++;
    end
    n_chk++; if (max_usage_o !== CW'(5)) $display("FAIL fill_max: got %0d exp 5", max_usage_o); else n_pass++;
    for (int unsigned i = 0; i < 3; i++) begin
      n_chk++; if (data_o !== DW'(8'hA1 + i)) $display("FAIL drain_data: got %h exp %h", data_o, 8'hA1 + i); else n_pass++;
      cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    n_chk++; if (max_usage_o !== CW'(2)) $display("FAIL errclr_max: got %0d exp 2", max_usage_o); else n_pass++;
    for (int unsigned i = 3; i < DEPTH; i++) begin
      n_chk++; if (data_o !== DW'(8'hA1 + i)) $display("FAIL drain_data: got %h exp %h", data_o, 8'hA1 + i); else n_pass++;
      cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    end
    n_chk++; if (empty_o !== 1'b1 || usage_o !== '0)
      $display("FAIL drain_empty: empty %b usage %0d exp 1 0", empty_o, usage_o); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] last;
    last = 8'h10;
    cycle(1'b1, 1'b0, last, 1'b0, 1'b0);
    for (int unsigned i = 1; i < 12; i++) begin
      n_chk++; if (data_o !== last) $display("FAIL wrap_data: step %0d got %h exp %h", i, data_o, last); else n_pass++;
      cycle(1'b1, 1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
      last = DW'(8'h10 + i);
      n_chk++; if (usage_o !== CW'(1)) $display("FAIL wrap_usage: step %0d got %0d exp 1", i, usage_o); else n_pass++;
    end
    n_chk++; if (data_o !== 8'h1B) $display("FAIL wrap_last: got %h exp 1b", data_o); else n_pass++;
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic test_full_push_pop();
    alm_full_th_i = 3'd7;
    for (int unsigned i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
    n_chk++; if (full_o !== 1'b1 || alm_full_o !== 1'b0)
      $display("FAIL fpp_full: full %b af %b exp 1 0", full_o, alm_full_o); else n_pass++;
    n_chk++; if (data_o !== mq[0]) $display("FAIL fpp_head: got %h exp %h", data_o, mq[0]); else n_pass++;
    cycle(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    n_chk++; if (usage_o !== CW'(4) || overflow_o !== 1'b1)
      $display("FAIL fpp_pop_only: usage %0d ovf %b exp 4 1", usage_o, overflow_o); else n_pass++;
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_chk++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", overflow_o); else n_pass++;
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    n_chk++; if (overflow_o !== 1'b0) $display("FAIL ovf_clr: got %b exp 0", overflow_o); else n_pass++;
    cycle(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h66, 1'b0, 1'b1);
    n_chk++; if (overflow_o !== 1'b1) $display("FAIL ovf_set_prio: got %b exp 1", overflow_o); else n_pass++;
    while (mq.size() > 0) cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    n_chk++; if (underflow_o !== 1'b1 || usage_o !== '0)
      $display("FAIL unf_set: unf %b usage %0d exp 1 0", underflow_o, usage_o); else n_pass++;
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 120; i++) begin
      alm_full_th_i  = CW'($urandom_range(0, 7));
      alm_empty_th_i = CW'($urandom_range(0, 7));
      if (mq.size() > 0) begin
        n_chk++; if (data_o !== mq[0]) $display("FAIL rnd_data: cyc %0d got %h exp %h", i, data_o, mq[0]); else n_pass++;
      end
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, DW'($urandom),
            1'b0, $urandom_range(0, 15) == 0);
      n_chk++; if (usage_o !== CW'(mq.size()) || full_o !== (mq.size() == DEPTH) || empty_o !== (mq.size() == 0))
        $display("FAIL rnd_occ: cyc %0d usage %0d full %b empty %b exp usage %0d", i, usage_o, full_o, empty_o, mq.size());
      else n_pass++;
      n_chk++; if (overflow_o !== m_ovf || underflow_o !== m_unf || max_usage_o !== CW'(m_max))
        $display("FAIL rnd_err: cyc %0d ovf %b unf %b max %0d exp %b %b %0d", i, overflow_o, underflow_o, max_usage_o, m_ovf, m_unf, m_max);
      else n_pass++;
      n_chk++; if (alm_full_o !== (mq.size() >= alm_full_th_i) || alm_empty_o !== (mq.size() <= alm_empty_th_i))
        $display("FAIL rnd_alm: cyc %0d af %b ae %b usage %0d th %0d/%0d", i, alm_full_o, alm_empty_o, mq.size(), alm_full_th_i, alm_empty_th_i);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    while (mq.size() > 0) cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(8'h70 + i), 1'b0, 1'b0);
    n_chk++; if (usage_o !== CW'(3) || underflow_o !== 1'b1)
      $display("FAIL flush_pre: usage %0d unf %b exp 3 1", usage_o, underflow_o); else n_pass++;
    cycle(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
    n_chk++; if (usage_o !== '0 || empty_o !== 1'b1)
      $display("FAIL flush_occ: usage %0d empty %b exp 0 1", usage_o, empty_o); else n_pass++;
    n_chk++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0 || max_usage_o !== '0)
      $display("FAIL flush_err: ovf %b unf %b max %0d exp 0 0 0", overflow_o, underflow_o, max_usage_o); else n_pass++;
    cycle(1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    n_chk++; if (data_o !== 8'h42) $display("FAIL flush_after: got %h exp 42", data_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int unsigned i = 0; i < 2; i++) cycle(1'b1, 1'b0, DW'(8'h80 + i), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    push_i = 1'b1; data_i = 8'hCD;
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    n_chk++; if (usage_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0)
      $display("FAIL rstmid_occ: usage %0d empty %b full %b exp 0 1 0", usage_o, empty_o, full_o); else n_pass++;
    n_chk++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0 || max_usage_o !== '0)
      $display("FAIL rstmid_err: ovf %b unf %b max %0d exp 0 0 0", overflow_o, underflow_o, max_usage_o); else n_pass++;
    push_i = 1'b0;
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_fall_through();
    ft_push_i = 1'b1; ft_pop_i = 1'b1; ft_data_i = 8'h3C;
    #1;
    n_chk++; if (ft_data_o !== 8'h3C || ft_empty_o !== 1'b0)
      $display("FAIL ft_pass_data: data %h empty %b exp 3c 0", ft_data_o, ft_empty_o); else n_pass++;
    @(posedge clk_i);
    #1;
    ft_push_i = 1'b0; ft_pop_i = 1'b0;
    n_chk++; if (ft_usage_o !== '0 || ft_unf_o !== 1'b0 || ft_ovf_o !== 1'b0)
      $display("FAIL ft_pass_usage: usage %0d unf %b ovf %b exp 0 0 0", ft_usage_o, ft_unf_o, ft_ovf_o); else n_pass++;
    ft_push_i = 1'b1; ft_data_i = 8'h5A;
    #1;
    n_chk++; if (ft_data_o !== 8'h5A) $display("FAIL ft_push_data: got %h exp 5a", ft_data_o); else n_pass++;
    @(posedge clk_i);
    #1;
    ft_push_i = 1'b0; ft_data_i = 8'h00;
    #1;
    n_chk++; if (ft_usage_o !== CW'(1) || ft_data_o !== 8'h5A)
      $display("FAIL ft_stored: usage %0d data %h exp 1 5a", ft_usage_o, ft_data_o); else n_pass++;
    ft_pop_i = 1'b1;
    @(posedge clk_i);
    #1;
    ft_pop_i = 1'b0;
    n_chk++; if (ft_usage_o !== '0 || ft_empty_o !== 1'b1)
      $display("FAIL ft_drain: usage %0d empty %b exp 0 1", ft_usage_o, ft_empty_o); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, exp completion");
    $fatal(1, "tb_fifo_v4 timeout");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_push_pop();
    test_random();
    test_flush();
    test_reset_mid();
    test_fall_through();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
